// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo: FIFO-buffered 8N1 UART transmitter for a 7-bit char stream.  |
// | Macro UART_TX_PARITY_EN inserts an even-parity bit between DATA and STOP.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
   parameter int  CLKS_PER_BIT = 868,
   parameter int  FIFO_DEPTH   = 16,
   localparam int ADDR_W       = $clog2(FIFO_DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [6:0]        char_i,
   input  logic              send_i,
   output logic              busy_o,
   output logic              out_o,
   output logic              idle_o,
   output logic [ADDR_W:0]   count_o,
   output logic              overflow_o
);

   localparam logic [15:0]     C_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0] C_DEPTH     = (ADDR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic [6:0]        mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_d;
   logic              overflow_q;
   state_t            state_q;
   logic [15:0]       baud_q;
   logic [2:0]        bit_q;
   logic [7:0]        shift_q;
   logic              out_q;
`ifdef UART_TX_PARITY_EN
   logic              parity_q;
`endif

   logic       w_push;
   logic       w_pop;
   logic       w_baud_end;
   logic [6:0] w_head;

   assign busy_o     = (count_q == C_DEPTH);
   assign idle_o     = (state_q == S_IDLE) && (count_q == '0);
   assign count_o    = count_q;
   assign overflow_o = overflow_q;
   assign out_o      = out_q;

   assign w_baud_end = (baud_q == C_BAUD_LAST);
   assign w_push     = send_i && !busy_o;
   // The next character is taken either from IDLE or on the last STOP cycle, so frames run back to back.
   assign w_pop      = (count_q != '0) &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && w_baud_end));
   assign w_head     = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (w_push && !w_pop) begin
         count_d = count_q + 1'b1;
      end else if (!w_push && w_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= char_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         if (send_i && busy_o) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         out_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         baud_q <= w_baud_end ? 16'd0 : baud_q + 16'd1;
         unique case (state_q)
            S_IDLE: begin
               baud_q <= '0;
               out_q  <= 1'b1;
               if (w_pop) begin
                  shift_q  <= {1'b0, w_head};
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^w_head;
`endif
                  out_q    <= 1'b0;
                  state_q  <= S_START;
               end
            end
            S_START: begin
               if (w_baud_end) begin
                  state_q <= S_DATA;
                  bit_q   <= '0;
                  out_q   <= shift_q[0];
               end
            end
            S_DATA: begin
               if (w_baud_end) begin
                  bit_q <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= S_PARITY;
                     out_q   <= parity_q;
`else
                     state_q <= S_STOP;
                     out_q   <= 1'b1;
`endif
                  end else begin
                     shift_q <= {1'b0, shift_q[7:1]};
                     out_q   <= shift_q[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_baud_end) begin
                  state_q <= S_STOP;
                  out_q   <= 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_baud_end) begin
                  if (w_pop) begin
                     shift_q  <= {1'b0, w_head};
`ifdef UART_TX_PARITY_EN
                     parity_q <= ^w_head;
`endif
                     out_q    <= 1'b0;
                     state_q  <= S_START;
                  end else begin
                     out_q    <= 1'b1;
                     state_q  <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               out_q   <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_fifo: self-checking bench for uart_tx_fifo against a queue-and- |
// | frame-timer reference model. Revision: 1.0                                 |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          send  = 1'b0;
   logic [6:0]    ch    = '0;
   logic          busy;
   logic          line;
   logic          idle;
   logic [AW:0]   count;
   logic          ovf;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .char_i     (ch),
      .send_i     (send),
      .busy_o     (busy),
      .out_o      (line),
      .idle_o     (idle),
      .count_o    (count),
      .overflow_o (ovf)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference: queue of accepted chars plus cycles left in the frame on the line.
   logic [6:0] m_q[$];
   int         m_left = 0;
   int         m_pops = 0;
   logic [6:0] m_cur  = '0;
   bit         m_ovf  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_line();
      int k;
      int b;
      if (m_left == 0) return 1'b1;
      k = FRAME - m_left;
      b = k / CPB;
      if (b == 0) return 1'b0;
      if (b <= 7) return m_cur[b-1];
      if (b == 8) return 1'b0;
      if (NBITS == 11 && b == 9) return ^m_cur;
      return 1'b1;
   endfunction

   task automatic step();
      int sz;
      bit pop;
      if (!rst_n) begin
         m_q.delete();
         m_left = 0;
         m_ovf  = 1'b0;
      end else begin
         sz  = m_q.size();
         pop = 1'b0;
         if (m_left > 0) m_left--;
         if (m_left == 0 && sz > 0) pop = 1'b1;
         if (send) begin
            if (sz < DEPTH) m_q.push_back(ch);
            else            m_ovf = 1'b1;
         end
         if (pop) begin
            m_cur  = m_q.pop_front();
            m_left = FRAME;
            m_pops++;
         end
      end
      @(posedge clk);
      #1;
      check("out",      32'(line),  32'(exp_line()));
      check("count",    32'(count), 32'(m_q.size()));
      check("busy",     32'(busy),  32'(m_q.size() == DEPTH));
      check("idle",     32'(idle),  32'(m_left == 0 && m_q.size() == 0));
      check("overflow", 32'(ovf),   32'(m_ovf));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push_char(input logic [6:0] c);
      send = 1'b1;
      ch   = c;
      step();
      send = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < (DEPTH + 2) * FRAME && !(m_left == 0 && m_q.size() == 0); i++) step();
      step();
      check("drain_idle", 32'(idle), 32'd1);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      cycles(2);
      rst_n = 1'b1;
   endtask

   task automatic wait_pop_next(input string tag);
      int i;
      for (i = 0; i < 4 * FRAME && m_left != 1; i++) step();
      check(tag, 32'(m_left == 1), 32'd1);
   endtask

   logic [10:0] a_bits = 11'h082;
   logic [7:0]  fizz [6] = '{8'h46, 8'h69, 8'h7a, 8'h7a, 8'h0d, 8'h0a};

   initial begin
      int n;
      int p0;
      int b;

      cycles(2);
      check("rst_out",   32'(line),  32'd1);
      check("rst_count", 32'(count), 32'd0);
      rst_n = 1'b1;
      cycles(3);

      // 'A' waveform against literal bit pattern
      push_char(7'h41);
      for (int k = 0; k < FRAME; k++) begin
         step();
         b = k / CPB;
         check("A_bit", 32'(line), (b == NBITS - 1) ? 32'd1 : 32'(a_bits[b]));
      end
      step();
      check("A_idle", 32'(idle), 32'd1);
      cycles(3);

      // 'C' frame length
      push_char(7'h43);
      n = 0;
      while (!idle && n < 200) begin
         step();
         n++;
      end
      check("C_frame_len", 32'(n), 32'(FRAME + 1));
      cycles(2);

      // 17 sends while the transmitter is mid-frame
      push_char(7'h55);
      cycles(10);
      for (int i = 0; i < 17; i++) push_char(7'(8'h30 + i));
      check("burst_count", 32'(count), 32'd16);
      check("burst_busy",  32'(busy),  32'd1);
      check("burst_ovf",   32'(ovf),   32'd1);
      drain();

      reset_pulse();
      check("ovf_cleared", 32'(ovf), 32'd0);

      // "Fizz\r\n" back to back
      for (int i = 0; i < 6; i++) push_char(fizz[i][6:0]);
      drain();

      // reset during DATA bit 3 of frame 2 of 3
      p0 = m_pops;
      for (int i = 0; i < 3; i++) push_char(7'(8'h61 + i));
      for (int i = 0; i < 4 * FRAME && !(m_pops == p0 + 2 && FRAME - m_left == 4 * CPB + 1); i++) step();
      check("mid_count", 32'(count), 32'd1);
      rst_n = 1'b0;
      step();
      check("mrst_out",   32'(line),  32'd1);
      check("mrst_count", 32'(count), 32'd0);
      check("mrst_idle",  32'(idle),  32'd1);
      rst_n = 1'b1;
      cycles(3 * FRAME);
      check("no_resend", 32'(idle), 32'd1);

      // push/pop coincidence at count 15 and 16
      for (int i = 0; i < 16; i++) push_char(7'(8'h40 + i));
      check("fill15", 32'(count), 32'd15);
      wait_pop_next("reach_pop15");
      push_char(7'h7e);
      check("cnt15_pop", 32'(count), 32'd15);
      push_char(7'h7d);
      check("cnt16", 32'(busy), 32'd1);
      wait_pop_next("reach_pop16");
      push_char(7'h7c);
      check("cnt16_pop",     32'(count), 32'd15);
      check("cnt16_pop_ovf", 32'(ovf),   32'd1);
      drain();
      reset_pulse();

      // randomized traffic at several densities
      for (int phase = 0; phase < 3; phase++) begin
         for (int i = 0; i < 700; i++) begin
            send = ($urandom_range(0, 99) < (phase == 0 ? 3 : (phase == 1 ? 15 : 60)));
            ch   = 7'($urandom);
            step();
         end
         send = 1'b0;
         drain();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
